// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: carries ALU result, store data, dest reg and MEM/WB control with a 2-entry skid buffer.
// Latency: 1 cycle from accept to presentation when the main register is free (EMPTY, or ONE with out_fire).
// Backpressure: in_ready (registered) drops once the skid entry is occupied; held beats stay stable until out_ready.
module ex_mem_pipe #(
    parameter int DATA_W          = 32,
    parameter int REG_W           = 5,
    parameter int ZERO_REG_SQUASH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              memwrite,
    input  logic              memread,
    input  logic              memtoreg,
    input  logic              regwrite,
    input  logic [REG_W-1:0]  writereg,
    input  logic [DATA_W-1:0] aluresult,
    input  logic [DATA_W-1:0] readreg2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              memwriteo,
    output logic              memreado,
    output logic              memtorego,
    output logic              regwriteo,
    output logic [REG_W-1:0]  rdo,
    output logic [DATA_W-1:0] aluresulto,
    output logic [DATA_W-1:0] readreg2o,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data
);

    // One pipeline beat; main and skid always move as whole beats so fields never mix.
    typedef struct packed {
        logic              memwrite;
        logic              memread;
        logic              memtoreg;
        logic              regwrite;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rr2;
    } beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_n;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;
    logic   in_ready_q;
    logic   in_fire;
    logic   out_fire;
    logic   load_main_in;
    logic   load_main_skid;
    logic   load_skid;
    logic   zero_dest;

    // A write to r0 can never be architecturally visible, so drop its regwrite on capture
    // to keep the forwarding tap from advertising it.
    assign zero_dest = (ZERO_REG_SQUASH != 0) && (writereg == '0);

    // Assemble the incoming beat, applying the zero-register squash.
    always_comb begin
        in_beat          = '0;
        in_beat.memwrite = memwrite;
        in_beat.memread  = memread;
        in_beat.memtoreg = memtoreg;
        in_beat.regwrite = regwrite & ~zero_dest;
        in_beat.rd       = writereg;
        in_beat.alu      = aluresult;
        in_beat.rr2      = readreg2;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    // Next-state and load-select decode; flush overrides every transfer.
    always_comb begin
        state_n        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_n = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_n      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                        state_n      = ST_ONE;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_n   = ST_TWO;
                    end else if (out_fire) begin
                        state_n = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        state_n        = ST_ONE;
                    end
                end
                default: begin
                    state_n = ST_EMPTY;
                end
            endcase
        end
    end

    // State and in_ready registers; in_ready is derived from the next state so it is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_n;
            in_ready_q <= (state_n != ST_TWO);
        end
    end

    // Main register: whole-beat loads; control is squashed whenever the stage goes empty,
    // while the data fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (state_n == ST_EMPTY) begin
                main_q.memwrite <= 1'b0;
                main_q.memread  <= 1'b0;
                main_q.memtoreg <= 1'b0;
                main_q.regwrite <= 1'b0;
            end
        end
    end

    // Skid register: captures the beat that arrives while the main beat is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_beat;
        end else if (flush) begin
            skid_q.memwrite <= 1'b0;
            skid_q.memread  <= 1'b0;
            skid_q.memtoreg <= 1'b0;
            skid_q.regwrite <= 1'b0;
        end
    end

    assign memwriteo  = main_q.memwrite;
    assign memreado   = main_q.memread;
    assign memtorego  = main_q.memtoreg;
    assign regwriteo  = main_q.regwrite;
    assign rdo        = main_q.rd;
    assign aluresulto = main_q.alu;
    assign readreg2o  = main_q.rr2;

    // Forwarding tap for the hazard unit: pure copies of the registered outputs.
    assign fwd_valid = out_valid & main_q.regwrite;
    assign fwd_reg   = main_q.rd;
    assign fwd_data  = main_q.alu;

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic        memwrite, memread, memtoreg, regwrite;
    logic [4:0]  writereg;
    logic [31:0] aluresult, readreg2;
    logic        out_valid, out_ready;
    logic        memwriteo, memreado, memtorego, regwriteo;
    logic [4:0]  rdo;
    logic [31:0] aluresulto, readreg2o;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DATA_W(32), .REG_W(5), .ZERO_REG_SQUASH(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .memwrite(memwrite), .memread(memread), .memtoreg(memtoreg), .regwrite(regwrite),
        .writereg(writereg), .aluresult(aluresult), .readreg2(readreg2),
        .out_valid(out_valid), .out_ready(out_ready),
        .memwriteo(memwriteo), .memreado(memreado), .memtorego(memtorego), .regwriteo(regwriteo),
        .rdo(rdo), .aluresulto(aluresulto), .readreg2o(readreg2o),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [4:0] wr, input logic rw, input logic mw,
                        input logic [31:0] alu);
        in_valid  = v;
        writereg  = wr;
        regwrite  = rw;
        memwrite  = mw;
        memread   = 1'b0;
        memtoreg  = 1'b0;
        aluresult = alu;
        readreg2  = alu ^ 32'hFFFF_0000;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, ".ctrl"}, {60'd0, memwriteo, memreado, memtorego, regwriteo}, 64'd0);
        chk({tag, ".data"}, {rdo, aluresulto, readreg2o}, 64'd0);
        chk({tag, ".fwd"}, {fwd_valid, fwd_reg, fwd_data}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        beat(1'b1, 5'd9, 1'b1, 1'b1, 32'hDEAD);
        step();
        step();
        chk_reset_vals("reset");

        // Streaming: four beats back to back, out_ready high.
        rst = 1'b0;
        beat(1'b1, 5'd3, 1'b1, 1'b0, 32'h10); step();
        chk("s1.alu", {32'd0, aluresulto}, 64'h10);
        chk("s1.vld_rdy", {62'd0, out_valid, in_ready}, 64'd3);
        chk("s1.rr2", {32'd0, readreg2o}, 64'hFFFF_0010);
        beat(1'b1, 5'd3, 1'b1, 1'b0, 32'h20); step();
        chk("s2.alu", {32'd0, aluresulto}, 64'h20);
        chk("s2.rdy", {63'd0, in_ready}, 64'd1);
        beat(1'b1, 5'd3, 1'b1, 1'b0, 32'h30); step();
        chk("s3.alu", {32'd0, aluresulto}, 64'h30);
        beat(1'b1, 5'd3, 1'b1, 1'b0, 32'h40); step();
        chk("s4.alu", {32'd0, aluresulto}, 64'h40);
        chk("s4.fwd", {fwd_valid, fwd_reg, fwd_data}, {1'b1, 5'd3, 32'h40});
        beat(1'b0, 5'd3, 1'b1, 1'b0, 32'h99); step();
        chk("s.drain.vld", {63'd0, out_valid}, 64'd0);
        chk("s.drain.alu", {32'd0, aluresulto}, 64'h40);

        // Back-pressure into the skid.
        beat(1'b1, 5'd1, 1'b1, 1'b0, 32'hA); step();
        out_ready = 1'b0;
        beat(1'b1, 5'd2, 1'b1, 1'b0, 32'hB); step();
        chk("bp.rdy_low", {63'd0, in_ready}, 64'd0);
        chk("bp.hold_a", {32'd0, aluresulto}, 64'hA);
        beat(1'b0, 5'd0, 1'b0, 1'b0, 32'h0); step();
        chk("bp.hold_a2", {rdo, aluresulto}, {5'd1, 32'hA});
        chk("bp.vld", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1; step();
        chk("bp.b_out", {rdo, aluresulto}, {5'd2, 32'hB});
        chk("bp.rdy_back", {62'd0, out_valid, in_ready}, 64'd3);
        step();
        chk("bp.empty", {63'd0, out_valid}, 64'd0);

        // Flush while two beats are held, with 0xC offered.
        beat(1'b1, 5'd1, 1'b1, 1'b1, 32'hA); step();
        out_ready = 1'b0;
        beat(1'b1, 5'd2, 1'b1, 1'b1, 32'hB); step();
        chk("fl.two", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        beat(1'b1, 5'd4, 1'b1, 1'b1, 32'hC); step();
        chk("fl.vld", {63'd0, out_valid}, 64'd0);
        chk("fl.ctrl", {60'd0, memwriteo, memreado, memtorego, regwriteo}, 64'd0);
        chk("fl.rdy", {63'd0, in_ready}, 64'd1);
        // Flush also drops an input that would otherwise fire from EMPTY.
        step();
        chk("fl.drop_in", {63'd0, out_valid}, 64'd0);
        flush = 1'b0; out_ready = 1'b1;
        beat(1'b0, 5'd0, 1'b0, 1'b0, 32'h0); step();
        chk("fl.no_c", {63'd0, out_valid}, 64'd0);
        chk("fl.fwd", {63'd0, fwd_valid}, 64'd0);

        // Bubble squash.
        beat(1'b1, 5'd4, 1'b1, 1'b1, 32'h77); step();
        chk("bub.ctrl_on", {62'd0, regwriteo, memwriteo}, 64'd3);
        beat(1'b0, 5'd4, 1'b1, 1'b1, 32'h88); step();
        chk("bub.ctrl_off", {61'd0, out_valid, regwriteo, memwriteo}, 64'd0);
        chk("bub.alu_kept", {32'd0, aluresulto}, 64'h77);

        // Zero-register squash and forwarding tap.
        beat(1'b1, 5'd0, 1'b1, 1'b0, 32'h55); step();
        chk("zr.out", {58'd0, out_valid, rdo, regwriteo, fwd_valid}, {58'd0, 1'b1, 5'd0, 2'b00});
        chk("zr.alu", {32'd0, aluresulto}, 64'h55);
        beat(1'b1, 5'd7, 1'b1, 1'b0, 32'h55); step();
        chk("nz.fwd", {fwd_valid, fwd_reg, fwd_data}, {1'b1, 5'd7, 32'h55});
        chk("nz.rw", {63'd0, regwriteo}, 64'd1);

        // Reset while stalled in TWO.
        out_ready = 1'b0;
        beat(1'b1, 5'd8, 1'b1, 1'b1, 32'hD1); step();
        chk("rs.two", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        beat(1'b0, 5'd0, 1'b0, 1'b0, 32'h0); step();
        chk_reset_vals("rs");
        rst = 1'b0; out_ready = 1'b1; step();
        chk("rs.no_held", {63'd0, out_valid}, 64'd0);
        step();
        chk("rs.no_held2", {32'd0, aluresulto}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline stage for the 5-stage MIPS core. It carries the ALU result, store data, destination register and the MEM/WB control bits from execute to memory. Unlike a bare per-cycle register, it has a valid/ready handshake with a 2-entry skid buffer, so a memory stall back-pressures execute without losing a beat. It also supports a synchronous flush, squashes control on bubbles, and drives a forwarding tap for the hazard unit.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, destination register index width
- ZERO_REG_SQUASH, 1, when 1 a write to register 0 is captured with regwrite cleared

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill all held beats and the current input beat
- in_valid  in  1  execute offers a beat
- in_ready  out  1  stage can accept a beat; registered
- memwrite, memread, memtoreg, regwrite  in  1 each  control bits of the incoming beat
- writereg  in  REG_W  destination register
- aluresult  in  DATA_W  ALU result / memory address
- readreg2  in  DATA_W  store data
- out_valid  out  1  a beat is presented to memory stage
- out_ready  in  1  memory stage accepts the beat
- memwriteo, memreado, memtorego, regwriteo  out  1 each  control of the presented beat
- rdo  out  REG_W  destination register of the presented beat
- aluresulto, readreg2o  out  DATA_W  data of the presented beat
- fwd_valid  out  1  equals out_valid & regwriteo
- fwd_reg  out  REG_W  equals rdo
- fwd_data  out  DATA_W  equals aluresulto

## Operation
- Definitions: in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Storage is a main register, which drives the outputs, plus a skid register.
- State machine EMPTY / ONE / TWO:
  - EMPTY, out_valid=0: on in_fire, load main and go to ONE.
  - ONE, main valid:
    - in_fire & out_fire: reload main, stay in ONE.
    - in_fire & !out_fire: load skid, go to TWO.
    - out_fire only: go to EMPTY.
    - neither: hold.
  - TWO, main and skid valid, in_ready=0: on out_fire, main<=skid and go to ONE. Otherwise hold.
- in_ready register is 1 in EMPTY/ONE and 0 in TWO, computed from the next state.
- flush has priority over every transfer: next state is EMPTY, in_ready=1, and the input beat is dropped even if in_fire.
- The main register loads held or incoming fields as a whole beat. Fields never mix between beats.
- Squash rules:
  - When the next state is EMPTY, all four control outputs are registered to 0.
  - rdo, aluresulto and readreg2o keep their last value.
- With ZERO_REG_SQUASH=1, a beat with writereg==0 is stored with regwrite=0; all its other fields are kept.
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Reset: in the cycle after rst is sampled high, the outputs are:
  - in_ready=1
  - out_valid=0
  - all control outputs 0
  - rdo, aluresulto, readreg2o, fwd_* all 0
  - state EMPTY, skid cleared
- Inputs are ignored while rst is high. rst mid-operation discards both beats.
- Latency is 1 cycle: a beat accepted at edge N is on the outputs after edge N, when the stage was EMPTY, or was in ONE with out_fire.
- Throughput is 1 beat/cycle while out_ready=1.
- in_ready deasserts the cycle after the skid fills. It reasserts the cycle after the TWO-state out_fire.
- Held outputs must stay stable while out_valid=1 and out_ready=0.
- Simultaneous flush and out_fire: the presented beat is considered consumed. The stage still goes EMPTY.
- fwd_* are combinational copies of registered outputs. They add no extra latency.

## Test plan
- Reset then stream: rst for 2 cycles, then 4 beats with aluresult 0x10,0x20,0x30,0x40 and out_ready=1.
  - The same values must appear on aluresulto on consecutive cycles, starting 1 cycle after each accept.
  - in_ready must stay 1 throughout.
- Back-pressure: drop out_ready with 0xA accepted and 0xB offered.
  - 0xB goes to skid and in_ready=0 next cycle.
  - Outputs hold 0xA.
  - On out_ready=1, 0xA then 0xB are delivered in order, with no loss or duplication.
- Flush in TWO: with beats 0xA/0xB held, assert flush with in_valid=1 carrying 0xC.
  - Next cycle: out_valid=0, all control outputs 0, in_ready=1.
  - 0xC is never output.
- Bubble squash: send regwrite=1, memwrite=1, then in_valid=0 with out_ready=1.
  - After the drain: regwriteo=memwriteo=0, out_valid=0.
  - aluresulto retains its last value.
- Zero-register: writereg=0, regwrite=1, aluresult=0x55.
  - Output: rdo=0, regwriteo=0, fwd_valid=0, aluresulto=0x55.
  - The same beat with writereg=7 gives fwd_valid=1, fwd_reg=7, fwd_data=0x55.
- Reset mid-stall: assert rst in state TWO.
  - Next cycle: all outputs at reset values and in_ready=1.
  - Neither held beat is ever output.
